// File: rtl/ctrl_pattern_tx.sv
// ctrl_pattern_tx: MSB-first serial pattern transmitter with repeat, inter-repeat gap and start/busy/done handshake
module ctrl_pattern_tx #(
  parameter int WIDTH = 16,
  parameter int LW = 5,
  parameter int GAP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    length,
  input  logic [7:0]       repeat_cnt,
  output logic             ctrl_out,
  output logic             busy,
  output logic             done,
  output logic [LW-1:0]    bit_idx
);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  localparam logic [LW-1:0] WL = LW'(WIDTH);
  localparam logic [GW-1:0] GL = GW'(GAP > 0 ? GAP - 1 : 0);
  typedef enum logic [1:0] {IDLE, SHIFT, GAPS, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] pat_q, pat_n;
  logic [LW-1:0] len_q, len_n, idx_n, eff_len;
  logic [7:0] rep_q, rep_n;
  logic [GW-1:0] gap_q, gap_n;
  logic accept, bit_n;
  assign eff_len = (length == '0 || length > WL) ? WL : length;
  assign accept = (state == IDLE || state == DONE) && start && !abort;
  assign bit_n = |(pat_n & ({{(WIDTH-1){1'b0}}, 1'b1} << idx_n));
  always_comb begin
    state_n = state;
    pat_n = pat_q;
    len_n = len_q;
    rep_n = rep_q;
    gap_n = gap_q;
    idx_n = bit_idx;
    case (state)
      IDLE, DONE: begin
        state_n = accept ? SHIFT : IDLE;
        pat_n = accept ? pattern : pat_q;
        len_n = accept ? eff_len : len_q;
        rep_n = accept ? repeat_cnt : rep_q;
        idx_n = accept ? eff_len - 1'b1 : '0;
      end
      SHIFT: begin
        if (abort) begin
          state_n = IDLE;
          idx_n = '0;
        end else if (bit_idx != '0) begin
          idx_n = bit_idx - 1'b1;
        end else if (rep_q != 8'd0) begin
          rep_n = rep_q - 8'd1;
          state_n = GAP > 0 ? GAPS : SHIFT;
          gap_n = GL;
          idx_n = GAP > 0 ? '0 : len_q - 1'b1;
        end else begin
          state_n = DONE;
          idx_n = '0;
        end
      end
      GAPS: begin
        state_n = abort ? IDLE : (gap_q == '0 ? SHIFT : GAPS);
        gap_n = gap_q - 1'b1;
        idx_n = (!abort && gap_q == '0) ? len_q - 1'b1 : '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pat_q <= '0;
      len_q <= '0;
      rep_q <= '0;
      gap_q <= '0;
      bit_idx <= '0;
      ctrl_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      pat_q <= pat_n;
      len_q <= len_n;
      rep_q <= rep_n;
      gap_q <= gap_n;
      bit_idx <= idx_n;
      ctrl_out <= state_n == SHIFT && bit_n;
      busy <= state_n == SHIFT || state_n == GAPS;
      done <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_ctrl_pattern_tx.sv
// tb_ctrl_pattern_tx: directed self-checking bench for ctrl_pattern_tx
module tb_ctrl_pattern_tx;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0] length = '0;
  logic [7:0] repeat_cnt = '0;
  logic ctrl_out, busy, done;
  logic [4:0] bit_idx;
  int passed = 0, total = 0;
  ctrl_pattern_tx #(.WIDTH(16), .LW(5), .GAP(2)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pattern(pattern),
    .length(length), .repeat_cnt(repeat_cnt), .ctrl_out(ctrl_out), .busy(busy),
    .done(done), .bit_idx(bit_idx)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, ".ctrl"}, 32'(ctrl_out), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".idx"}, 32'(bit_idx), 0);
  endtask
  task automatic launch(input logic [15:0] p, input logic [4:0] l, input logic [7:0] r);
    pattern = p;
    length = l;
    repeat_cnt = r;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic run(input string tag, input logic [31:0] bits, input int n, input bit with_idx);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.ctrl[%0d]", tag, i), 32'(ctrl_out), 32'(bits[n-1-i]));
      chk($sformatf("%s.busy[%0d]", tag, i), 32'(busy), 1);
      chk($sformatf("%s.done[%0d]", tag, i), 32'(done), 0);
      if (with_idx) chk($sformatf("%s.idx[%0d]", tag, i), 32'(bit_idx), 32'(n-1-i));
      step();
    end
    chk({tag, ".done_pulse"}, 32'(done), 1);
    chk({tag, ".done_busy"}, 32'(busy), 0);
    chk({tag, ".done_ctrl"}, 32'(ctrl_out), 0);
  endtask
  initial begin
    repeat (3) begin
      step();
      idle_chk("reset");
    end
    reset = 1'b0;
    repeat (5) begin
      step();
      idle_chk("idle");
    end
    launch(16'h00B5, 5'd8, 8'd0);
    run("basic", 32'hB5, 8, 1'b1);
    step();
    idle_chk("basic_after");
    launch(16'h0005, 5'd3, 8'd2);
    run("gap", 32'b1010010100101, 13, 1'b0);
    step();
    idle_chk("gap_after");
    launch(16'h8001, 5'd0, 8'd0);
    run("len0", 32'h8001, 16, 1'b1);
    step();
    launch(16'h0001, 5'd1, 8'd0);
    run("len1", 32'h1, 1, 1'b1);
    step();
    idle_chk("len1_after");
    launch(16'h00C3, 5'd8, 8'd0);
    pattern = 16'hFFFF;
    length = 5'd4;
    repeat_cnt = 8'd1;
    start = 1'b1;
    run("latched", 32'hC3, 8, 1'b1);
    step();
    start = 1'b0;
    run("b2b", 32'b1111001111, 10, 1'b0);
    step();
    idle_chk("b2b_after");
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    idle_chk("abort_start");
    step();
    idle_chk("abort_start2");
    launch(16'h00B5, 5'd8, 8'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort.ctrl[%0d]", i), 32'(ctrl_out), 32'(i != 1));
      step();
    end
    chk("abort.bit4", 32'(ctrl_out), 1);
    chk("abort.idx4", 32'(bit_idx), 4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    idle_chk("abort_next");
    step();
    idle_chk("abort_nodone");
    launch(16'h00B5, 5'd8, 8'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst.ctrl[%0d]", i), 32'(ctrl_out), 32'(i != 1));
      step();
    end
    chk("rst.bit4", 32'(ctrl_out), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_chk("rst_next");
    step();
    idle_chk("rst_nodone");
    launch(16'h00B5, 5'd8, 8'd0);
    run("post_rst", 32'hB5, 8, 1'b1);
    step();
    idle_chk("final");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ctrl_pattern_tx.md
# ctrl_pattern_tx

Serial stimulus transmitter that drives a one-bit `control` stream, one bit per clock. It feeds the Mealy sequence detectors in this design from a loaded pattern word, MSB-first, with programmable length, repeat count and inter-repeat gap. A start/busy/done handshake lets a testbench or a higher-level sequencer push patterns without cycle counting.

## Interface
- `WIDTH`, 16: maximum pattern length in bits.
- `LW`, 5: width of `length`; must hold values 0..WIDTH.
- `GAP`, 2: idle cycles (ctrl_out = 0) inserted between repetitions; 0 = back-to-back.
- `clk`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high; sampled on posedge clk.
- `start`  in  1  request; accepted on a posedge where start=1 and busy=0.
- `abort`  in  1  synchronous cancel of an active transmission.
- `pattern`  in  WIDTH  bits to send; bit [L-1] goes first, bit [0] goes last.
- `length`  in  LW  number of bits L. 0 or >WIDTH is treated as WIDTH.
- `repeat_cnt`  in  8  extra repetitions; total sends = repeat_cnt+1.
- `ctrl_out`  out  1  registered serial bit; 0 when not shifting.
- `busy`  out  1  high while shifting or in a gap.
- `done`  out  1  one-cycle pulse after the last bit of the last repetition.
- `bit_idx`  out  LW  index of the bit currently on ctrl_out; 0 when idle.

## Operation
- States:
  - IDLE: busy=0.
  - SHIFT: busy=1.
  - GAP: busy=1, ctrl_out=0.
  - DONE: one cycle, busy=0, done=1.
- Reset values: state IDLE; ctrl_out=0, busy=0, done=0, bit_idx=0; internal shift register, bit counter and repeat counter cleared.
- Accept (IDLE or DONE, start=1, abort=0):
  - latch pattern, effective L and repeat_cnt;
  - go to SHIFT with ctrl_out = pattern[L-1] and bit_idx = L-1.
- SHIFT, each cycle:
  - if bit_idx > 0: shift to the next lower bit, decrement bit_idx.
  - if bit_idx = 0 and repeats remain: decrement the repeat counter. Go to GAP if GAP>0, else reload to pattern[L-1] directly (no idle bit).
  - if bit_idx = 0 and no repeats remain: go to DONE.
- GAP: exactly GAP cycles with ctrl_out=0, then SHIFT from pattern[L-1].
- DONE: ctrl_out=0. Next state is IDLE, or SHIFT if start=1 in this cycle (back-to-back transmissions allowed).
- Latched values: pattern/length/repeat_cnt changes while busy=1 are ignored; only the values captured at acceptance are used.
- start while busy=1: ignored, not queued.
- abort=1 while busy=1: next edge goes to IDLE, ctrl_out=0, bit_idx=0, no done pulse.
- abort=1 with start=1 in IDLE: abort wins; no transmission starts.
- reset mid-transmission: same as abort, plus all counters cleared. reset has priority over abort and start.

## Timing
- start sampled high at edge k:
  - first bit on ctrl_out during cycle k+1;
  - bit j (MSB-first) during cycle k+1+j.
- Single send: busy high cycles k+1..k+L; done high cycle k+L+1, with busy=0 in that cycle.
- With repeats R: busy spans (R+1)·L + R·GAP cycles; done follows the final bit by one cycle.
- ctrl_out, busy, done and bit_idx are all registered; there is no combinational path from any input to any output.
- Throughput: a new start in the DONE cycle puts its first bit in the next cycle, so there is exactly one idle cycle between back-to-back patterns.

## Test plan
- Reset and idle: assert reset 3 cycles, then idle 5 cycles -> ctrl_out=0, busy=0, done=0, bit_idx=0 throughout.
- Basic send: pattern=16'h00B5, length=8, repeat_cnt=0, start one cycle -> ctrl_out = 1,0,1,1,0,1,0,1 in cycles k+1..k+8; busy high those 8 cycles; done high only at k+9.
- Repeat with gap (GAP=2): pattern=16'h0005, length=3, repeat_cnt=2 -> ctrl_out = 101 00 101 00 101; busy for 13 cycles; one done pulse.
- Length edge cases:
  - length=0 with pattern=16'h8001 -> 16 bits: 1, fourteen 0s, 1.
  - length=1 with pattern[0]=1 -> a single 1, then done at k+2.
- Interference: raise start again mid-send and change pattern while busy -> output unchanged from the latched pattern. start asserted in the DONE cycle -> new first bit the next cycle.
- Abort/reset mid-operation: abort at the 4th bit of an 8-bit send -> ctrl_out=0 and busy=0 from the next cycle, no done. Repeat the case with reset instead -> identical outputs, and a subsequent start behaves like the basic send.
